// File: rtl/quad_encoder_conditioner.sv
// quad_encoder_conditioner: sync + glitch filter + quadrature decode for SA/SB; QUAD_GLITCH_CNT_EN enables glitch_cnt
module quad_encoder_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 1000,
  parameter int POS_W       = 32
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    SA,
  input  logic                    SB,
  input  logic                    err_clr,
  output logic                    sa_clean,
  output logic                    sb_clean,
  output logic                    dir,
  output logic signed [POS_W-1:0] pos,
  output logic                    edge_stb,
  output logic                    quad_err,
  output logic                    init_done,
  output logic [15:0]             glitch_cnt
);
  localparam logic [15:0] FC_TC   = 16'(FILT_CYCLES - 1);
  localparam logic [16:0] INIT_TC = 17'(SYNC_STAGES + FILT_CYCLES + 1);
  typedef enum logic {INIT, TRACK} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sh [2];
  logic [15:0] fc [2];
  logic [1:0]  raw, syn, filt, prev_ab;
  logic [16:0] init_cnt;
  logic        init_tc, fwd, rev, ill;
  assign raw      = {SA, SB};
  assign syn      = {sh[1][SYNC_STAGES-1], sh[0][SYNC_STAGES-1]};
  assign sa_clean = filt[1];
  assign sb_clean = filt[0];
  always_ff @(posedge clk) begin
    if (!arst) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) begin
        sh[i] <= '0;
        fc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        sh[i] <= {sh[i][SYNC_STAGES-2:0], raw[i]};
        fc[i] <= (syn[i] != filt[i] && fc[i] != FC_TC) ? fc[i] + 16'd1 : 16'd0;
        if (syn[i] != filt[i] && fc[i] == FC_TC) filt[i] <= syn[i];
      end
    end
  end
  always_ff @(posedge clk) state <= !arst ? INIT : state_nx;
  always_comb begin
    init_tc  = state == INIT && init_cnt == INIT_TC;
    state_nx = init_tc ? TRACK : state;
  end
  // Gray-code successor tables: forward 00->10->11->01, reverse 00->01->11->10
  assign fwd = state == TRACK && filt == {~prev_ab[0], prev_ab[1]};
  assign rev = state == TRACK && filt == {prev_ab[0], ~prev_ab[1]};
  assign ill = state == TRACK && filt == ~prev_ab;
  always_ff @(posedge clk) begin
    if (!arst) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
      prev_ab   <= '0;
      pos       <= '0;
      dir       <= 1'b1;
      edge_stb  <= 1'b0;
      quad_err  <= 1'b0;
    end else begin
      init_cnt  <= init_cnt + 17'(state == INIT);
      init_done <= init_done | init_tc;
      prev_ab   <= filt;
      pos       <= fwd ? pos + 1'b1 : rev ? pos - 1'b1 : pos;
      dir       <= fwd ? 1'b1 : rev ? 1'b0 : dir;
      edge_stb  <= fwd | rev;
      quad_err  <= ill | (quad_err & ~err_clr);
    end
  end
`ifdef QUAD_GLITCH_CNT_EN
  logic [1:0]  glitch;
  logic [16:0] gsum;
  assign glitch = ~(syn ^ filt) & {|fc[1], |fc[0]};
  assign gsum   = {1'b0, glitch_cnt} + 17'(glitch[1]) + 17'(glitch[0]);
  always_ff @(posedge clk)
    glitch_cnt <= (!arst || err_clr) ? 16'h0 : gsum[16] ? 16'hFFFF : gsum[15:0];
`else
  assign glitch_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_quad_encoder_conditioner.sv
// tb_quad_encoder_conditioner: directed bench for quad_encoder_conditioner (SYNC_STAGES=2, FILT_CYCLES=4, POS_W=8)
module tb_quad_encoder_conditioner;
  logic clk = 1'b0, arst = 1'b0, SA = 1'b0, SB = 1'b0, err_clr = 1'b0;
  logic sa_clean, sb_clean, dir, edge_stb, quad_err, init_done;
  logic [7:0]  pos;
  logic [15:0] glitch_cnt;
  logic [1:0]  ab = 2'b00;
  int checks = 0, failures = 0, stb_cnt = 0, stb_base;
`ifdef QUAD_GLITCH_CNT_EN
  localparam int GLITCH_EXP = 5;
`else
  localparam int GLITCH_EXP = 0;
`endif
  quad_encoder_conditioner #(.SYNC_STAGES(2), .FILT_CYCLES(4), .POS_W(8)) dut (
    .clk(clk), .arst(arst), .SA(SA), .SB(SB), .err_clr(err_clr),
    .sa_clean(sa_clean), .sb_clean(sb_clean), .dir(dir), .pos(pos),
    .edge_stb(edge_stb), .quad_err(quad_err), .init_done(init_done), .glitch_cnt(glitch_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (edge_stb === 1'b1) stb_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input logic [1:0] v);
    ab = v;
    SA = v[1];
    SB = v[0];
  endtask
  initial begin
    step(3);
    check("rst_pos", pos, 0);
    check("rst_dir", dir, 1);
    check("rst_qerr", quad_err, 0);
    check("rst_init", init_done, 0);
    check("rst_sa", sa_clean, 0);
    check("rst_stb", edge_stb, 0);
    check("rst_glitch", glitch_cnt, 0);
    arst = 1'b1;
    step(7);
    check("init_7", init_done, 0);
    step(1);
    check("init_8", init_done, 1);
    check("init_pos", pos, 0);
    check("init_dir", dir, 1);
    check("init_qerr", quad_err, 0);
    check("init_stb", stb_cnt, 0);
    stb_base = stb_cnt;
    drive(2'b10);
    step(5);
    check("sa_lat5", sa_clean, 0);
    step(1);
    check("sa_lat6", sa_clean, 1);
    check("pos_pre", pos, 0);
    step(1);
    check("step1_pos", pos, 1);
    check("step1_dir", dir, 1);
    check("step1_stb", edge_stb, 1);
    step(1);
    check("step1_stb_off", edge_stb, 0);
    step(18);
    drive(2'b11); step(20); check("fwd_11", pos, 2);
    drive(2'b01); step(20); check("fwd_01", pos, 3);
    drive(2'b00); step(20); check("fwd_00", pos, 4);
    check("fwd_dir", dir, 1);
    check("fwd_sb", sb_clean, 0);
    drive(2'b01); step(20); check("rev_01", pos, 3);
    check("rev_dir", dir, 0);
    check("rev_sb", sb_clean, 1);
    drive(2'b11); step(20); check("rev_11", pos, 2);
    drive(2'b10); step(20); check("rev_10", pos, 1);
    drive(2'b00); step(20); check("rev_00", pos, 0);
    check("stb_total", stb_cnt - stb_base, 8);
    for (int i = 0; i < 5; i++) begin
      SA = 1'b1; step(3);
      SA = 1'b0; step(10);
      check("glitch_sa", sa_clean, 0);
    end
    check("glitch_pos", pos, 0);
    check("glitch_stb", stb_cnt - stb_base, 8);
    check("glitch_cnt", glitch_cnt, GLITCH_EXP);
    drive(2'b11); step(20);
    check("ill_qerr", quad_err, 1);
    check("ill_pos", pos, 0);
    check("ill_stb", stb_cnt - stb_base, 8);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    check("clr_qerr", quad_err, 0);
    check("clr_glitch", glitch_cnt, 0);
    drive(2'b00); step(6);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    check("set_wins", quad_err, 1);
    check("set_wins_pos", pos, 0);
    step(5);
    for (int i = 0; i < 127; i++) begin
      drive({~ab[0], ab[1]});
      step(8);
    end
    check("wrap_7f", pos, 8'h7F);
    check("wrap_dir", dir, 1);
    drive({~ab[0], ab[1]}); step(8);
    check("wrap_80", pos, 8'h80);
    drive({ab[0], ~ab[1]}); step(8);
    check("unwrap_7f", pos, 8'h7F);
    check("unwrap_dir", dir, 0);
    drive({~ab[0], ab[1]}); step(3);
    arst = 1'b0; step(1);
    check("mid_pos", pos, 0);
    check("mid_dir", dir, 1);
    check("mid_qerr", quad_err, 0);
    check("mid_init", init_done, 0);
    check("mid_sa", sa_clean, 0);
    check("mid_sb", sb_clean, 0);
    check("mid_stb", edge_stb, 0);
    check("mid_glitch", glitch_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
